instr_prefetch_queue: RTL and testbench

//  Instruction-fetch front end of the 16-bit pipelined processor. Sits between the

---
 rtl/instr_prefetch_queue.sv | 120 ++++++++++++
 tb/tb_instr_prefetch_queue.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_prefetch_queue.sv
// Instruction-fetch front end: issues sequential fetches, buffers returned words
// with their PC in a small FIFO and hands them to decode over valid/ready.
module instr_prefetch_queue #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 4,
    parameter int PTR_WIDTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic                  halt_req,
    input  logic                  redirect,
    input  logic [ADDR_WIDTH-1:0] redirect_addr,
    output logic                  im_rd,
    output logic [ADDR_WIDTH-1:0] im_addr,
    input  logic [DATA_WIDTH-1:0] im_r_data,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [DATA_WIDTH-1:0] inst_data,
    output logic [ADDR_WIDTH-1:0] inst_pc,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    localparam logic [PTR_WIDTH:0] COUNT_FULL = (PTR_WIDTH + 1)'(DEPTH);

    state_t                 state;
    state_t                 state_next;
    logic [ADDR_WIDTH-1:0]  pc;
    logic [PTR_WIDTH:0]     count;
    logic [PTR_WIDTH-1:0]   wr_ptr;
    logic [PTR_WIDTH-1:0]   rd_ptr;
    logic [DATA_WIDTH-1:0]  data_mem [DEPTH];
    logic [ADDR_WIDTH-1:0]  pc_mem   [DEPTH];

    logic start_go;
    logic redirect_go;
    logic flush;
    logic push;
    logic pop;

    // Start only acts outside RUN; redirect only inside RUN. Either empties the queue.
    assign start_go    = start & (state != RUN);
    assign redirect_go = redirect & (state == RUN);
    assign flush       = start_go | redirect_go;

    assign im_rd      = (state == RUN) & (count < COUNT_FULL) & ~redirect & ~halt_req;
    assign im_addr    = pc;
    assign push       = im_rd;
    assign inst_valid = (count != '0);
    assign pop        = inst_valid & inst_ready & ~flush;
    assign busy       = (state != IDLE);

    // Head outputs are forced to zero while empty, so stale storage never leaks out.
    assign inst_data = inst_valid ? data_mem[rd_ptr] : '0;
    assign inst_pc   = inst_valid ? pc_mem[rd_ptr]   : '0;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start)    state_next = RUN;
            RUN:     if (halt_req) state_next = HALTED;
            HALTED:  if (start)    state_next = RUN;
            default:               state_next = IDLE;
        endcase
    end

    // NOTE: reset is synchronous, so it is simply the highest-priority branch of the clocked block.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc     <= '0;
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            pc     <= start_go ? start_addr : redirect_addr;
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                pc     <= pc + ADDR_WIDTH'(1);
                wr_ptr <= wr_ptr + PTR_WIDTH'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_WIDTH'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (PTR_WIDTH + 1)'(1);
                2'b01:   count <= count - (PTR_WIDTH + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array is deliberately not reset; validity lives in count,
    // and the head outputs are masked whenever the queue is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr] <= im_r_data;
            pc_mem[wr_ptr]   <= pc;
        end
    end

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Self-checking bench for instr_prefetch_queue: per-cycle vector table plus
// hand-written redirect/wrap/halt/reset sequences, with a scoreboard on accepted words.
module tb_instr_prefetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  start_addr;
    logic        halt_req;
    logic        redirect;
    logic [7:0]  redirect_addr;
    logic        im_rd;
    logic [7:0]  im_addr;
    logic [15:0] im_r_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [15:0] inst_data;
    logic [7:0]  inst_pc;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] sb [$];

    typedef struct {
        logic       rst_before;
        logic       start;
        logic [7:0] start_addr;
        logic       ready;
        logic       exp_rd;
        logic [7:0] exp_addr;
        logic       exp_valid;
        logic [7:0] exp_pc;
        logic       exp_busy;
    } vec_t;

    localparam int NVEC = 19;
    vec_t vecs [NVEC];

    instr_prefetch_queue #(
        .ADDR_WIDTH(8), .DATA_WIDTH(16), .DEPTH(4), .PTR_WIDTH(2)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .start_addr(start_addr),
        .halt_req(halt_req), .redirect(redirect), .redirect_addr(redirect_addr),
        .im_rd(im_rd), .im_addr(im_addr), .im_r_data(im_r_data),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data),
        .inst_pc(inst_pc), .busy(busy)
    );

    always #5 clk = ~clk;

    // Instruction memory image: IM[k] = k + 0x100.
    assign im_r_data = {8'h01, im_addr};

    function automatic vec_t mk(logic rb, logic st, logic [7:0] sa, logic rdy,
                                logic erd, logic [7:0] ea, logic ev, logic [7:0] ep, logic eb);
        vec_t v;
        v.rst_before = rb; v.start = st; v.start_addr = sa; v.ready = rdy;
        v.exp_rd = erd; v.exp_addr = ea; v.exp_valid = ev; v.exp_pc = ep; v.exp_busy = eb;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic settle();
        #1;
    endtask

    // Scoreboard compare on an accepted word, then advance one clock.
    task automatic edge_clk();
        logic [7:0] exp_pc;
        if (inst_valid === 1'b1 && inst_ready && !redirect && !start) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL sb_extra_pop: got pc %0h expected no pop", inst_pc);
            end else begin
                exp_pc = sb.pop_front();
                check("sb_pc", {24'h0, inst_pc}, {24'h0, exp_pc});
                check("sb_data", {16'h0, inst_data}, {16'h0, 8'h01, exp_pc});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        check("sb_drained_before_reset", sb.size(), 0);
        rst = 1'b0; start = 1'b0; halt_req = 1'b0; redirect = 1'b0; inst_ready = 1'b0;
        settle();
        edge_clk();
        rst = 1'b1;
    endtask

    task automatic check_out(input string tag, input logic erd, input logic [7:0] ea,
                             input logic ev, input logic [7:0] ep, input logic eb);
        check({tag, "_im_rd"}, {31'h0, im_rd}, {31'h0, erd});
        if (erd) check({tag, "_im_addr"}, {24'h0, im_addr}, {24'h0, ea});
        check({tag, "_valid"}, {31'h0, inst_valid}, {31'h0, ev});
        if (ev) begin
            check({tag, "_pc"}, {24'h0, inst_pc}, {24'h0, ep});
            check({tag, "_data"}, {16'h0, inst_data}, {16'h0, 8'h01, ep});
        end
        check({tag, "_busy"}, {31'h0, busy}, {31'h0, eb});
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; start_addr = '0; halt_req = 1'b0;
        redirect = 1'b0; redirect_addr = '0; inst_ready = 1'b0;

        // Streaming at full rate from address 0.
        vecs[0]  = mk(1, 1, 8'h00, 1, 0, 8'h00, 0, 8'h00, 0);
        vecs[1]  = mk(0, 0, 8'h00, 1, 1, 8'h00, 0, 8'h00, 1);
        vecs[2]  = mk(0, 0, 8'h00, 1, 1, 8'h01, 1, 8'h00, 1);
        vecs[3]  = mk(0, 0, 8'h00, 1, 1, 8'h02, 1, 8'h01, 1);
        vecs[4]  = mk(0, 0, 8'h00, 1, 1, 8'h03, 1, 8'h02, 1);
        vecs[5]  = mk(0, 0, 8'h00, 1, 1, 8'h04, 1, 8'h03, 1);
        // Back-pressure: queue fills after 4 issues, then drains and refetch resumes at 4.
        vecs[6]  = mk(1, 1, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0);
        vecs[7]  = mk(0, 0, 8'h00, 0, 1, 8'h00, 0, 8'h00, 1);
        vecs[8]  = mk(0, 0, 8'h00, 0, 1, 8'h01, 1, 8'h00, 1);
        vecs[9]  = mk(0, 0, 8'h00, 0, 1, 8'h02, 1, 8'h00, 1);
        vecs[10] = mk(0, 0, 8'h00, 0, 1, 8'h03, 1, 8'h00, 1);
        vecs[11] = mk(0, 0, 8'h00, 0, 0, 8'h00, 1, 8'h00, 1);
        vecs[12] = mk(0, 0, 8'h00, 0, 0, 8'h00, 1, 8'h00, 1);
        vecs[13] = mk(0, 0, 8'h00, 0, 0, 8'h00, 1, 8'h00, 1);
        vecs[14] = mk(0, 0, 8'h00, 1, 0, 8'h00, 1, 8'h00, 1);
        vecs[15] = mk(0, 0, 8'h00, 1, 1, 8'h04, 1, 8'h01, 1);
        vecs[16] = mk(0, 0, 8'h00, 1, 1, 8'h05, 1, 8'h02, 1);
        vecs[17] = mk(0, 0, 8'h00, 1, 1, 8'h06, 1, 8'h03, 1);
        vecs[18] = mk(0, 0, 8'h00, 1, 1, 8'h07, 1, 8'h04, 1);

        // Reset state.
        do_reset();
        settle();
        check("rst_im_rd", {31'h0, im_rd}, 0);
        check("rst_valid", {31'h0, inst_valid}, 0);
        check("rst_busy", {31'h0, busy}, 0);
        check("rst_im_addr", {24'h0, im_addr}, 0);
        check("rst_inst_data", {16'h0, inst_data}, 0);
        check("rst_inst_pc", {24'h0, inst_pc}, 0);

        for (int i = 0; i < NVEC; i++) begin
            if (vecs[i].rst_before) do_reset();
            start      = vecs[i].start;
            start_addr = vecs[i].start_addr;
            inst_ready = vecs[i].ready;
            settle();
            check_out($sformatf("vec%0d", i), vecs[i].exp_rd, vecs[i].exp_addr,
                      vecs[i].exp_valid, vecs[i].exp_pc, vecs[i].exp_busy);
            if (vecs[i].exp_valid && vecs[i].ready) sb.push_back(vecs[i].exp_pc);
            edge_clk();
        end
        inst_ready = 1'b0;

        // Redirect with a simultaneous pop while pc 5..7 are queued.
        do_reset();
        start = 1'b1; start_addr = 8'h05; settle(); edge_clk();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin settle(); edge_clk(); end
        redirect = 1'b1; redirect_addr = 8'h20; inst_ready = 1'b1;
        settle();
        check_out("redir_same", 0, 8'h00, 1, 8'h05, 1);
        edge_clk();
        redirect = 1'b0;
        settle();
        check_out("redir_next", 1, 8'h20, 0, 8'h00, 1);
        edge_clk();
        sb.push_back(8'h20);
        settle();
        check_out("redir_head", 1, 8'h21, 1, 8'h20, 1);
        edge_clk();
        inst_ready = 1'b0;

        // PC wrap from 0xFE.
        do_reset();
        start = 1'b1; start_addr = 8'hFE; inst_ready = 1'b1; settle(); edge_clk();
        start = 1'b0;
        sb.push_back(8'hFE); sb.push_back(8'hFF); sb.push_back(8'h00); sb.push_back(8'h01);
        settle();
        check_out("wrap_first", 1, 8'hFE, 0, 8'h00, 1);
        edge_clk();
        settle(); edge_clk();
        settle();
        check_out("wrap_zero", 1, 8'h00, 1, 8'hFF, 1);
        edge_clk();
        settle(); edge_clk();
        settle(); edge_clk();
        inst_ready = 1'b0;

        // Halt with two entries queued, drain in HALTED, then restart at 0x10.
        do_reset();
        start = 1'b1; start_addr = 8'h00; settle(); edge_clk();
        start = 1'b0;
        settle(); edge_clk();
        settle(); edge_clk();
        halt_req = 1'b1;
        settle();
        check_out("halt_same", 0, 8'h00, 1, 8'h00, 1);
        edge_clk();
        halt_req = 1'b0; inst_ready = 1'b1;
        sb.push_back(8'h00); sb.push_back(8'h01);
        settle();
        check_out("halt_drain0", 0, 8'h00, 1, 8'h00, 1);
        edge_clk();
        settle();
        check_out("halt_drain1", 0, 8'h00, 1, 8'h01, 1);
        edge_clk();
        settle();
        check_out("halt_empty", 0, 8'h00, 0, 8'h00, 1);
        inst_ready = 1'b0; start = 1'b1; start_addr = 8'h10;
        settle(); edge_clk();
        start = 1'b0;
        settle();
        check_out("restart_fetch", 1, 8'h10, 0, 8'h00, 1);
        edge_clk();
        inst_ready = 1'b1;
        sb.push_back(8'h10);
        settle();
        check_out("restart_head", 1, 8'h11, 1, 8'h10, 1);
        edge_clk();
        inst_ready = 1'b0;

        // Reset asserted mid-RUN with three entries queued.
        do_reset();
        start = 1'b1; start_addr = 8'h40; settle(); edge_clk();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin settle(); edge_clk(); end
        rst = 1'b0; settle(); edge_clk();
        rst = 1'b1;
        settle();
        check_out("midrst", 0, 8'h00, 0, 8'h00, 0);
        check("midrst_im_addr", {24'h0, im_addr}, 0);
        check("midrst_inst_pc", {24'h0, inst_pc}, 0);
        check("midrst_inst_data", {16'h0, inst_data}, 0);
        edge_clk();
        start = 1'b1; start_addr = 8'h50; settle(); edge_clk();
        start = 1'b0;
        settle();
        check_out("midrst_refetch", 1, 8'h50, 0, 8'h00, 1);
        edge_clk();
        inst_ready = 1'b1;
        sb.push_back(8'h50);
        settle();
        check_out("midrst_head", 1, 8'h51, 1, 8'h50, 1);
        edge_clk();
        inst_ready = 1'b0;

        check("sb_drained_final", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
